// File: rtl/interlock_input_bank.sv
// Interlock input bank: per-channel synchronizer + debounce, fault latching,
// first-out capture, permit generation and a saturating latch-event counter.

// One channel's front end: metastability synchronizer followed by a
// consecutive-cycle debounce filter on the synchronized level.
module interlock_input_chan #(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic filt
);
    localparam int CW = (DEBOUNCE_CYC < 2) ? 1 : $clog2(DEBOUNCE_CYC);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;
    logic                   synced;
    logic                   differ;

    assign synced = sync_q[SYNC_STAGES-1];
    assign differ = synced ^ filt;

    // Shift the raw pin through the synchronizer chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
    end

    // Accept the new level only after DEBOUNCE_CYC consecutive differing cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            filt <= 1'b0;
        end else if (!differ) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
            cnt  <= '0;
            filt <= synced;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

module interlock_input_bank #(
    parameter int              N_CH         = 8,
    parameter int              SYNC_STAGES  = 2,
    parameter int              DEBOUNCE_CYC = 4,
    parameter logic [N_CH-1:0] INV_MASK     = '0,
    localparam int             IW           = (N_CH > 2) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] in_raw,
    input  logic [N_CH-1:0] ch_en,
    input  logic            clear_hold,
    input  logic            lamp_test,
    output logic [N_CH-1:0] filt_o,
    output logic [N_CH-1:0] latch_o,
    output logic [N_CH-1:0] la_o,
    output logic            permit_o,
    output logic            first_valid_o,
    output logic [IW-1:0]   first_idx_o,
    output logic [7:0]      event_cnt_o
);
    logic [N_CH-1:0] live;
    logic [N_CH-1:0] set_v;
    logic [N_CH-1:0] latch_nxt;
    logic [N_CH-1:0] newly;

    // Lowest set bit index of a channel vector (0 when empty).
    function automatic logic [IW-1:0] lowest(input logic [N_CH-1:0] v);
        logic [IW-1:0] r;
        r = '0;
        for (int i = N_CH - 1; i >= 0; i--)
            if (v[i]) r = IW'(i);
        return r;
    endfunction

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        interlock_input_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_chan (
            .clk  (clk),
            .reset(reset),
            .pin  (in_raw[g]),
            .filt (filt_o[g])
        );
    end

    // Set wins over clear; clear only releases channels whose fault is gone.
    always_comb begin
        live      = filt_o ^ INV_MASK;
        set_v     = live & ch_en;
        latch_nxt = set_v | (latch_o & ~({N_CH{clear_hold}} & ~live));
        newly     = latch_nxt & ~latch_o;
    end

    assign la_o = lamp_test ? {N_CH{1'b1}} : latch_o;

    // Latch, permit, first-out and event counter all update together so
    // permit drops on the very edge a latch sets.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            latch_o       <= '0;
            permit_o      <= 1'b0;
            first_valid_o <= 1'b0;
            first_idx_o   <= '0;
            event_cnt_o   <= '0;
        end else begin
            latch_o  <= latch_nxt;
            permit_o <= ~|latch_nxt & ~|set_v;

            if (clear_hold) begin
                first_valid_o <= |latch_nxt;
                first_idx_o   <= lowest(latch_nxt);
            end else if (!first_valid_o && |newly) begin
                first_valid_o <= 1'b1;
                first_idx_o   <= lowest(newly);
            end

            if (clear_hold && ~|latch_nxt)
                event_cnt_o <= '0;
            else if (|newly && event_cnt_o != 8'd255)
                event_cnt_o <= event_cnt_o + 8'd1;
        end
    end
endmodule

// File: tb/tb_interlock_input_bank.sv
// Directed bench for interlock_input_bank at default parameters.
module tb_interlock_input_bank;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_raw;
    logic [7:0] ch_en;
    logic       clear_hold;
    logic       lamp_test;
    logic [7:0] filt_o, latch_o, la_o;
    logic       permit_o, first_valid_o;
    logic [2:0] first_idx_o;
    logic [7:0] event_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    interlock_input_bank dut (
        .clk          (clk),
        .reset        (reset),
        .in_raw       (in_raw),
        .ch_en        (ch_en),
        .clear_hold   (clear_hold),
        .lamp_test    (lamp_test),
        .filt_o       (filt_o),
        .latch_o      (latch_o),
        .la_o         (la_o),
        .permit_o     (permit_o),
        .first_valid_o(first_valid_o),
        .first_idx_o  (first_idx_o),
        .event_cnt_o  (event_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr;
        clear_hold = 1'b1;
        tick();
        clear_hold = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_raw = '0; ch_en = 8'hFF; clear_hold = 0; lamp_test = 0;
        tick(2);
        chk("rst_latch", latch_o, 0);
        chk("rst_permit", permit_o, 0);
        chk("rst_cnt", event_cnt_o, 0);
        chk("rst_fv", first_valid_o, 0);
        reset = 1'b0;
        tick();
        chk("permit_idle", permit_o, 1);

        // single fault on ch3: filt at edge 6, latch at edge 7
        in_raw = 8'h08;
        tick(5);
        chk("filt3_e5", filt_o, 8'h00);
        tick();
        chk("filt3_e6", filt_o, 8'h08);
        chk("latch3_e6", latch_o, 8'h00);
        chk("permit_e6", permit_o, 1);
        tick();
        chk("latch3_e7", latch_o, 8'h08);
        chk("la3", la_o, 8'h08);
        chk("permit3", permit_o, 0);
        chk("idx3", first_idx_o, 3);
        chk("fv3", first_valid_o, 1);
        chk("cnt3", event_cnt_o, 1);

        in_raw = 8'h00;
        tick(6);
        chk("hold_no_clr", latch_o, 8'h08);
        clr();
        chk("clr_latch", latch_o, 0);
        chk("clr_fv", first_valid_o, 0);
        chk("clr_cnt", event_cnt_o, 0);
        chk("clr_permit", permit_o, 1);

        // 3-cycle glitch on ch2 is filtered out
        in_raw = 8'h04;
        tick(3);
        in_raw = 8'h00;
        tick(10);
        chk("glitch_filt", filt_o, 0);
        chk("glitch_latch", latch_o, 0);
        chk("glitch_permit", permit_o, 1);

        // ch5 and ch1 together, then ch0 later
        in_raw = 8'h22;
        tick(7);
        chk("dual_latch", latch_o, 8'h22);
        chk("dual_idx", first_idx_o, 1);
        chk("dual_cnt", event_cnt_o, 1);
        in_raw = 8'h23;
        tick(7);
        chk("ch0_latch", latch_o, 8'h23);
        chk("ch0_idx", first_idx_o, 1);
        chk("ch0_cnt", event_cnt_o, 2);

        // clear with ch1 still live
        in_raw = 8'h02;
        tick(6);
        clr();
        chk("part_latch", latch_o, 8'h02);
        chk("part_idx", first_idx_o, 1);
        chk("part_fv", first_valid_o, 1);
        chk("part_cnt", event_cnt_o, 2);
        in_raw = 8'h00;
        tick(6);
        clr();
        chk("all_clr", latch_o, 0);
        chk("all_idx", first_idx_o, 0);
        chk("all_cnt", event_cnt_o, 0);

        // disabled channel blocks set; re-enable latches; disable does not clear
        ch_en = 8'hBF;
        in_raw = 8'h40;
        tick(8);
        chk("dis_filt", filt_o, 8'h40);
        chk("dis_latch", latch_o, 0);
        chk("dis_permit", permit_o, 1);
        ch_en = 8'hFF;
        tick();
        chk("en_latch", latch_o, 8'h40);
        chk("en_idx", first_idx_o, 6);
        chk("en_permit", permit_o, 0);
        ch_en = 8'hBF;
        clr();
        chk("live_hold", latch_o, 8'h40);
        in_raw = 8'h00;
        tick(6);
        clr();
        chk("ch6_clr", latch_o, 0);
        ch_en = 8'hFF;

        // lamp test
        lamp_test = 1'b1;
        tick();
        chk("lamp_la", la_o, 8'hFF);
        chk("lamp_latch", latch_o, 0);
        chk("lamp_permit", permit_o, 1);
        lamp_test = 1'b0;

        // saturation: ch0 held latched, ch7 cycled 300 times
        in_raw = 8'h01;
        tick(7);
        chk("sat_start", event_cnt_o, 1);
        for (int i = 0; i < 300; i++) begin
            in_raw = 8'h81;
            tick(7);
            in_raw = 8'h01;
            tick(6);
            clr();
            if (i == 9) chk("sat_mid", event_cnt_o, 11);
        end
        chk("sat_end", event_cnt_o, 255);
        chk("sat_latch", latch_o, 8'h01);

        // async reset between edges
        #2;
        reset = 1'b1;
        #1;
        chk("arst_latch", latch_o, 0);
        chk("arst_la", la_o, 0);
        chk("arst_filt", filt_o, 0);
        chk("arst_permit", permit_o, 0);
        chk("arst_cnt", event_cnt_o, 0);
        chk("arst_fv", first_valid_o, 0);
        reset = 1'b0;
        in_raw = 8'h00;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/interlock_input_bank.md
INTERLOCK_INPUT_BANK -- requirements
Module: interlock_input_bank

Interface
REQ-001 The block SHALL have parameter N_CH, default 8, giving the channel count (2..32).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth (>=2).
REQ-003 The block SHALL have parameter DEBOUNCE_CYC, default 4, giving the consecutive stable cycles needed for a filtered change (>=1).
REQ-004 The block SHALL have parameter INV_MASK [N_CH-1:0], default 0; a 1 makes that channel active-low (fault when the pin is 0).
REQ-005 Port clk, input, 1 bit: the single clock.
REQ-006 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port in_raw, input, N_CH bits: asynchronous interlock pins.
REQ-008 Port ch_en, input, N_CH bits: per-channel latch enable; 0 masks the channel.
REQ-009 Port clear_hold, input, 1 bit: synchronous request to clear held errors.
REQ-010 Port lamp_test, input, 1 bit: forces all lamp outputs on.
REQ-011 Port filt_o, output, N_CH bits: debounced pin level.
REQ-012 Port latch_o, output, N_CH bits: held fault per channel.
REQ-013 Port la_o, output, N_CH bits: lamp drive.
REQ-014 Port permit_o, output, 1 bit: 1 when operation is permitted.
REQ-015 Port first_valid_o, output, 1 bit: qualifies first_idx_o.
REQ-016 Port first_idx_o, output, max(1,clog2(N_CH)) bits: index of the first-latched channel.
REQ-017 Port event_cnt_o, output, 8 bits: saturating count of latch events.

Function
REQ-018 Each in_raw bit SHALL pass through SYNC_STAGES flops before any other use.
REQ-019 A per-channel counter SHALL count consecutive cycles in which the synced value differs from filt_o, and reset to 0 on any cycle where they match.
REQ-020 filt_o SHALL take the synced value on the edge that ends the DEBOUNCE_CYC-th consecutive differing cycle, and the counter SHALL clear on that same edge.
REQ-021 A glitch shorter than DEBOUNCE_CYC cycles after synchronization SHALL NOT change filt_o.
REQ-022 Live fault for channel i SHALL be defined as filt_o[i] XOR INV_MASK[i].
REQ-023 latch_o[i] SHALL set one edge after live fault[i]=1 with ch_en[i]=1; ch_en=0 SHALL block setting but SHALL NOT clear an existing latch.
REQ-024 clear_hold SHALL clear latch_o[i] only where live fault[i]=0; when set and clear coincide, set SHALL win.
REQ-025 la_o SHALL equal all-ones when lamp_test=1, and latch_o otherwise (combinational from registers).
REQ-026 permit_o SHALL be registered and equal 1 only when latch_o==0 and no enabled channel has a live fault.
REQ-027 When first_valid_o=0 and one or more channels newly latch in a cycle, first_idx_o SHALL capture the lowest such index and first_valid_o SHALL become 1, same edge as latch_o.
REQ-028 While first_valid_o=1, later latches SHALL NOT change first_idx_o.
REQ-029 On clear_hold, if any latch remains, first_idx_o SHALL become the lowest remaining latched index with first_valid_o=1; otherwise first_valid_o SHALL become 0 and first_idx_o SHALL become 0.
REQ-030 event_cnt_o SHALL increment by 1 on each edge where at least one latch bit goes 0->1, saturate at 255, and clear to 0 on clear_hold only when all latches clear.
REQ-031 Pin-to-latch latency SHALL be SYNC_STAGES+DEBOUNCE_CYC+1 edges (7 at defaults); permit_o SHALL drop on the same edge as latch_o sets.

Reset
REQ-032 Reset SHALL asynchronously zero the sync flops, debounce counters, filt_o, latch_o, first_valid_o, first_idx_o, event_cnt_o, and permit_o (fail-safe).
REQ-033 After reset release, channels with INV_MASK=1 and ch_en=1 SHALL latch on the first edge, because filt=0 reads as a fault.
REQ-034 Reset asserted mid-debounce or mid-latch SHALL discard all state, with no partial update.

Verification
REQ-035 Defaults: in_raw[3] 0->1 held -> filt_o[3]=1 after 6 edges, latch_o[3]=1, la_o[3]=1, permit_o=0, first_idx_o=3, event_cnt_o=1 at edge 7.
REQ-036 3-cycle pulse on in_raw[2] -> filt_o, latch_o, and permit_o unchanged.
REQ-037 Faults on ch 5 and ch 1 reach latch on the same edge, then ch 0 later -> first_idx_o=1, event_cnt_o=2.
REQ-038 clear_hold with ch 1 fault still live, ch 5 removed -> latch_o={ch1} only, first_idx_o=1, first_valid_o=1.
REQ-039 lamp_test=1 with no faults -> la_o=0xFF, latch_o=0, permit_o=1; 300 latch events -> event_cnt_o=255.
REQ-040 Async reset pulse between clock edges during a latched fault -> all outputs 0 immediately, without waiting for a clock edge.
